// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters, RAW/overflow hazard
// detection and a RUN/STALL/FLUSH issue FSM. Optional macro: SCOREBOARD_BYPASS_EN.
module reg_scoreboard (
    input  logic        clock,
    input  logic        reset,
    input  logic        issueValid,
    input  logic [4:0]  srcA,
    input  logic        srcAUsed,
    input  logic [4:0]  srcB,
    input  logic        srcBUsed,
    input  logic        destValid,
    input  logic [4:0]  dest,
    input  logic        wbValid,
    input  logic [4:0]  wbReg,
    input  logic        flush,
    output logic        issueReady,
    output logic        stalled,
    output logic [31:0] busyMask,
    output logic [15:0] stallCycles,
    output logic        wbError
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} stateType;

    stateType    state;
    stateType    nextState;
    logic [1:0]  pendCnt [32];
    logic [31:0] incVec;
    logic [31:0] decVec;
    logic        srcAHazard;
    logic        srcBHazard;
    logic        destFull;
    logic        hazard;
    logic        fire;

    always_comb begin
        srcAHazard = srcAUsed && (srcA != 5'd31) && (pendCnt[srcA] != 2'd0);
        srcBHazard = srcBUsed && (srcB != 5'd31) && (pendCnt[srcB] != 2'd0);
`ifdef SCOREBOARD_BYPASS_EN
        // The last outstanding write to a source retiring now is forwarded.
        if (wbValid && (wbReg == srcA) && (pendCnt[srcA] == 2'd1))
            srcAHazard = 1'b0;
        if (wbValid && (wbReg == srcB) && (pendCnt[srcB] == 2'd1))
            srcBHazard = 1'b0;
`endif
        destFull   = destValid && (dest != 5'd31) && (pendCnt[dest] == 2'd3);
        hazard     = srcAHazard || srcBHazard || destFull;
        issueReady = ((state == RUN) || (state == STALL)) && !flush && !hazard;
        fire       = issueValid && issueReady;

        nextState = state;
        case (state)
            RUN:     if (issueValid && hazard) nextState = STALL;
            STALL:   if (!issueValid || !hazard) nextState = RUN;
            FLUSH:   nextState = RUN;
            default: nextState = RUN;
        endcase
        if (flush)
            nextState = FLUSH;
    end

    // Register 31 is never tracked, so its increment/decrement lines stay low.
    always_comb begin
        incVec = '0;
        decVec = '0;
        for (int r = 0; r < 31; r++) begin
            incVec[r] = fire && destValid && (dest == 5'(r));
            decVec[r] = wbValid && (wbReg == 5'(r));
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= RUN;
        else
            state <= nextState;
    end

    // Same-cycle issue and writeback to one register cancel out.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int r = 0; r < 32; r++)
                pendCnt[r] <= 2'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (incVec[r] && !decVec[r])
                    pendCnt[r] <= pendCnt[r] + 2'd1;
                else if (!incVec[r] && decVec[r] && (pendCnt[r] != 2'd0))
                    pendCnt[r] <= pendCnt[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            wbError <= 1'b0;
        else if (!flush && wbValid && (wbReg != 5'd31) && (pendCnt[wbReg] == 2'd0))
            wbError <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            stallCycles <= 16'd0;
        else if (issueValid && !issueReady && (stallCycles != 16'hFFFF))
            stallCycles <= stallCycles + 16'd1;
    end

    always_comb begin
        busyMask = '0;
        for (int r = 0; r < 31; r++)
            busyMask[r] = (pendCnt[r] != 2'd0);
    end

    assign stalled = (state == STALL);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed scenarios plus random traffic,
// checked against a count-per-register reference model.
module tb_reg_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issueValid = 1'b0;
    logic [4:0]  srcA = '0;
    logic        srcAUsed = 1'b0;
    logic [4:0]  srcB = '0;
    logic        srcBUsed = 1'b0;
    logic        destValid = 1'b0;
    logic [4:0]  dest = '0;
    logic        wbValid = 1'b0;
    logic [4:0]  wbReg = '0;
    logic        flush = 1'b0;
    logic        issueReady;
    logic        stalled;
    logic [31:0] busyMask;
    logic [15:0] stallCycles;
    logic        wbError;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct { bit check; bit ready; } readyExp;
    typedef struct { logic [31:0] busy; bit stall; logic [15:0] cycles; bit err; } regExp;

    readyExp readyQ [$];
    regExp   regQ [$];

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: plain pending-write counts and a few flags.
    int pend [32];
    bit mStall = 0;
    bit mFlush = 0;
    int mCycles = 0;
    bit mErr = 0;
    bit modelKnown = 0;

    reg_scoreboard dut (
        .clock(clock), .reset(reset), .issueValid(issueValid),
        .srcA(srcA), .srcAUsed(srcAUsed), .srcB(srcB), .srcBUsed(srcBUsed),
        .destValid(destValid), .dest(dest), .wbValid(wbValid), .wbReg(wbReg),
        .flush(flush), .issueReady(issueReady), .stalled(stalled),
        .busyMask(busyMask), .stallCycles(stallCycles), .wbError(wbError)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit srcHazard(input bit used, input int r, input bit wv, input int wr);
        if (!used || r == 31 || pend[r] == 0) return 1'b0;
        if (BYPASS && pend[r] == 1 && wv && wr == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic applyStimulus(input bit iv, input logic [4:0] a, input bit au,
                                 input logic [4:0] b, input bit bu, input bit dv,
                                 input logic [4:0] d, input bit wv, input logic [4:0] wr,
                                 input bit fl, input bit rs);
        bit hz;
        bit rdy;
        int incReg;
        int decReg;
        readyExp re;
        regExp ge;
        @(negedge clock);
        issueValid = iv; srcA = a; srcAUsed = au; srcB = b; srcBUsed = bu;
        destValid = dv; dest = d; wbValid = wv; wbReg = wr; flush = fl; reset = rs;
        #1;
        hz = srcHazard(au, int'(a), wv, int'(wr)) || srcHazard(bu, int'(b), wv, int'(wr))
             || (dv && d != 5'd31 && pend[d] == 3);
        rdy = !mFlush && !fl && !hz;
        re.check = modelKnown && !rs;
        re.ready = rdy;
        readyQ.push_back(re);
        if (rs) begin
            foreach (pend[r]) pend[r] = 0;
            mStall = 0; mFlush = 0; mCycles = 0; mErr = 0;
        end else begin
            if (iv && !rdy && mCycles < 65535) mCycles++;
            if (fl) begin
                foreach (pend[r]) pend[r] = 0;
                mFlush = 1; mStall = 0;
            end else begin
                incReg = (iv && rdy && dv && d != 5'd31) ? int'(d) : -1;
                decReg = (wv && wr != 5'd31) ? int'(wr) : -1;
                if (decReg >= 0 && pend[decReg] == 0) mErr = 1;
                if (!(incReg >= 0 && incReg == decReg)) begin
                    if (incReg >= 0) pend[incReg]++;
                    if (decReg >= 0 && pend[decReg] > 0) pend[decReg]--;
                end
                if (mFlush) begin
                    mFlush = 0; mStall = 0;
                end else begin
                    mStall = iv && hz;
                end
            end
        end
        modelKnown = 1;
        ge.busy = '0;
        for (int r = 0; r < 32; r++) ge.busy[r] = (pend[r] != 0);
        ge.stall = mStall;
        ge.cycles = 16'(mCycles);
        ge.err = mErr;
        regQ.push_back(ge);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] pickReg();
        if ($urandom_range(0, 9) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    // Monitor: issueReady is checked mid-cycle, registered outputs just after each edge.
    initial begin
        readyExp re;
        regExp ge;
        forever begin
            @(negedge clock);
            #2;
            if (readyQ.size() > 0) begin
                re = readyQ.pop_front();
                if (re.check) checkOutput("issueReady", issueReady, re.ready);
            end
            @(posedge clock);
            #1;
            if (regQ.size() > 0) begin
                ge = regQ.pop_front();
                checkOutput("busyMask", busyMask, ge.busy);
                checkOutput("stalled", stalled, ge.stall);
                checkOutput("stallCycles", stallCycles, ge.cycles);
                checkOutput("wbError", wbError, ge.err);
            end
        end
    end

    initial begin
        int pendList [$];
        bit wv;
        logic [4:0] wr;
        foreach (pend[r]) pend[r] = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        checkOutput("resetBusy", busyMask, 0);
        checkOutput("resetStalled", stalled, 0);
        checkOutput("resetCycles", stallCycles, 0);
        checkOutput("resetErr", wbError, 0);

        // RAW hazard on r5 resolved by writeback
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        checkOutput("issue5Ready", issueReady, 1);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw5Blocked", issueReady, 0);
        checkOutput("busy5", busyMask[5], 1);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        checkOutput("raw5Stalled", stalled, 1);
        checkOutput("wb5SameCycle", issueReady, BYPASS);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw5Released", issueReady, 1);
        idle();

        // Fourth outstanding write to r7 must wait
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        checkOutput("r7Full", issueReady, 0);
        checkOutput("busy7", busyMask[7], 1);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        checkOutput("r7StillFull", issueReady, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // XZR is never tracked
        applyStimulus(1, 0, 0, 0, 0, 1, 31, 0, 0, 0, 0);
        checkOutput("xzrIssue", issueReady, 1);
        applyStimulus(1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("xzrRead", issueReady, 1);
        checkOutput("xzrBusy", busyMask, 0);
        idle();
        checkOutput("xzrNoStall", stalled, 0);

        // Spurious writeback
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        idle();
        checkOutput("wbErrSet", wbError, 1);
        checkOutput("busy9", busyMask[9], 0);

        // Flush with r3/r4 pending
        applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0);
        checkOutput("flushCycleReady", issueReady, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        checkOutput("flushStateReady", issueReady, 0);
        checkOutput("flushBusy", busyMask, 0);
        idle();
        checkOutput("postFlushReady", issueReady, 1);
        checkOutput("postFlushStalled", stalled, 0);

        // Reset in the middle of a stall
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("midStall", stalled, 1);
        applyStimulus(1, 2, 1, 0, 0, 1, 2, 1, 2, 1, 1);
        idle();
        checkOutput("rstBusy", busyMask, 0);
        checkOutput("rstStalled", stalled, 0);
        checkOutput("rstCycles", stallCycles, 0);
        checkOutput("rstErr", wbError, 0);

        // Random traffic; writebacks target registers the model knows are pending
        for (int n = 0; n < 3000; n++) begin
            pendList.delete();
            for (int r = 0; r < 31; r++) if (pend[r] > 0) pendList.push_back(r);
            wv = (pendList.size() > 0) && ($urandom_range(0, 9) < 4);
            wr = wv ? 5'(pendList[$urandom_range(0, pendList.size() - 1)]) : 5'd0;
            if ($urandom_range(0, 199) == 0 && !wv) begin
                wv = 1'b1;
                wr = pickReg();
            end
            applyStimulus($urandom_range(0, 9) < 7, pickReg(), 1'($urandom), pickReg(),
                          1'($urandom), 1'($urandom), pickReg(), wv, wr,
                          $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end

        idle();
        @(posedge clock);
        #3;
        checkOutput("queuesDrained", readyQ.size() + regQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
